// File: rtl/hnoc_pkg.sv
// Shared NoC helpers: port-count limits, destination-field extraction and
// address range matching used by the router route logic.
package hnoc_pkg;

    localparam int MIN_PORTS = 2;
    localparam int MAX_PORTS = 8;
    localparam int MAX_DW    = 256;
    localparam int MAX_AW    = 16;

    typedef logic [MAX_AW-1:0] addr_t;

    // Destination lives in the top aw bits of a dw-bit flit.
    function automatic addr_t addr_field(input logic [MAX_DW-1:0] flit,
                                         input int unsigned dw,
                                         input int unsigned aw);
        logic [MAX_DW-1:0] sh;
        addr_t             mask;
        sh   = flit >> (dw - aw);
        mask = '0;
        for (int b = 0; b < MAX_AW; b++)
            if (b < int'(aw)) mask[b] = 1'b1;
        return sh[MAX_AW-1:0] & mask;
    endfunction

    function automatic logic in_range(input addr_t a, input addr_t lo, input addr_t hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/hnoc_centre_router_if.sv
// Ingress/egress bundle of the centre router; master is the traffic
// environment, slave is the router side.
interface hnoc_centre_router_if #(
    parameter int NumPorts  = 4,
    parameter int DataWidth = 36
);
    logic [NumPorts*DataWidth-1:0] in_data;
    logic [NumPorts-1:0]           in_valid;
    logic [NumPorts-1:0]           in_ready;
    logic [NumPorts*DataWidth-1:0] out_data;
    logic [NumPorts-1:0]           out_valid;
    logic [NumPorts-1:0]           out_ready;

    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid);
    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid);
endinterface

// File: rtl/hnoc_fifo.sv
// Per-input flit FIFO with registered full; a freshly written head is hidden
// for one cycle so every flit sees the same two-edge ingress-to-egress latency.
module hnoc_fifo #(
    parameter int DataWidth = 36,
    parameter int Depth     = 4
) (
    input  logic                 i_sclk,
    input  logic                 i_reset,
    input  logic                 i_push,
    input  logic [DataWidth-1:0] i_data,
    input  logic                 i_pop,
    output logic [DataWidth-1:0] o_data,
    output logic                 o_full,
    output logic                 o_empty
);
    localparam int AW = $clog2(Depth);

    logic [DataWidth-1:0] r_mem [Depth];
    logic [AW-1:0]        r_wr, r_rd;
    logic [AW:0]          r_cnt, w_cnt_nxt;
    logic                 r_full, r_fresh;
    logic                 w_push, w_pop;

    assign o_empty   = (r_cnt == '0) || r_fresh;
    assign w_pop     = i_pop && !o_empty;
    assign w_push    = i_push && (!r_full || w_pop);
    assign w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign o_full    = r_full;
    assign o_data    = r_mem[r_rd];

    // r_full resets high so ready stays low until the first edge after release.
    always_ff @(posedge i_sclk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b1;
            r_fresh <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_cnt   <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == (AW+1)'(Depth));
            r_fresh <= w_push && (r_cnt == (AW+1)'(w_pop));
        end
    end

    always_ff @(posedge i_sclk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/hnoc_centre_router.sv
// Centre router: per-input FIFOs, address-range routing with uplink default,
// and per-output round-robin arbitration into a single egress register.
module hnoc_centre_router
    import hnoc_pkg::*;
#(
    parameter int                          NumPorts    = 4,
    parameter int                          DataWidth   = 36,
    parameter int                          AddrWidth   = 4,
    parameter int                          FifoDepth   = 4,
    parameter logic [NumPorts*AddrWidth-1:0] PortMin   = {4'd12, 4'd8, 4'd4, 4'd0},
    parameter logic [NumPorts*AddrWidth-1:0] PortMax   = {4'd13, 4'd11, 4'd7, 4'd3},
    parameter int                          DefaultPort = 3
) (
    input  logic                          i_sclk,
    input  logic                          i_reset,
    input  logic [NumPorts*DataWidth-1:0] i_data,
    input  logic [NumPorts-1:0]           i_data_valid,
    output logic [NumPorts-1:0]           o_data_ready,
    output logic [NumPorts*DataWidth-1:0] o_data,
    output logic [NumPorts-1:0]           o_data_valid,
    input  logic [NumPorts-1:0]           i_data_ready
);
    localparam int PW = $clog2(NumPorts);

    if (NumPorts < MIN_PORTS || NumPorts > MAX_PORTS ||
        DataWidth > MAX_DW || AddrWidth > MAX_AW) begin : g_bad_cfg
        $error("hnoc_centre_router: unsupported parameter set");
    end

    logic [NumPorts-1:0][DataWidth-1:0] w_head;
    logic [NumPorts-1:0]                w_empty, w_full, w_push, w_pop;
    logic [NumPorts-1:0][PW-1:0]        w_tgt;
    logic [NumPorts-1:0][NumPorts-1:0]  w_gnt;

    assign o_data_ready = ~w_full;
    assign w_push       = i_data_valid & ~w_full;

    for (genvar i = 0; i < NumPorts; i++) begin : g_in
        addr_t         w_dest;
        logic [PW-1:0] w_t;

        hnoc_fifo #(.DataWidth(DataWidth), .Depth(FifoDepth)) u_fifo (
            .i_sclk  (i_sclk),
            .i_reset (i_reset),
            .i_push  (w_push[i]),
            .i_data  (i_data[i*DataWidth +: DataWidth]),
            .i_pop   (w_pop[i]),
            .o_data  (w_head[i]),
            .o_full  (w_full[i]),
            .o_empty (w_empty[i])
        );

        assign w_dest = addr_field(MAX_DW'(w_head[i]), DataWidth, AddrWidth);

        // Scan high to low so the lowest-indexed matching port wins.
        always_comb begin
            w_t = PW'(DefaultPort);
            for (int p = NumPorts-1; p >= 0; p--)
                if (in_range(w_dest, MAX_AW'(PortMin[p*AddrWidth +: AddrWidth]),
                                     MAX_AW'(PortMax[p*AddrWidth +: AddrWidth])))
                    w_t = PW'(p);
        end
        assign w_tgt[i] = w_t;
    end

    always_comb begin
        w_pop = '0;
        for (int o = 0; o < NumPorts; o++)
            for (int i = 0; i < NumPorts; i++)
                w_pop[i] = w_pop[i] | w_gnt[o][i];
    end

    for (genvar o = 0; o < NumPorts; o++) begin : g_out
        logic [PW-1:0]        r_ptr, w_win, w_idx;
        logic                 w_any, w_free;
        logic [NumPorts-1:0]  w_g;
        logic [DataWidth-1:0] r_data;
        logic                 r_vld;

        always_comb begin
            w_any = 1'b0;
            w_win = '0;
            w_idx = '0;
            for (int k = 0; k < NumPorts; k++) begin
                w_idx = PW'((int'(r_ptr) + k) % NumPorts);
                if (!w_any && !w_empty[w_idx] && (w_tgt[w_idx] == PW'(o))) begin
                    w_any = 1'b1;
                    w_win = w_idx;
                end
            end
        end

        // Reload on the same edge the downstream drains, for 1 flit/cycle.
        assign w_free   = !r_vld || i_data_ready[o];
        assign w_g      = (w_any && w_free) ? ((NumPorts)'(1) << w_win) : '0;
        assign w_gnt[o] = w_g;

        always_ff @(posedge i_sclk or negedge i_reset) begin
            if (!i_reset) begin
                r_ptr  <= '0;
                r_data <= '0;
                r_vld  <= 1'b0;
            end else if (w_any && w_free) begin
                r_vld  <= 1'b1;
                r_data <= w_head[w_win];
                r_ptr  <= (w_win == PW'(NumPorts-1)) ? '0 : w_win + 1'b1;
            end else if (i_data_ready[o]) begin
                r_vld  <= 1'b0;
            end
        end

        assign o_data[o*DataWidth +: DataWidth] = r_data;
        assign o_data_valid[o]                  = r_vld;
    end

endmodule

// File: tb/tb_hnoc_centre_router.sv
// Directed-vector bench for hnoc_centre_router with default 4-port ranges.
module tb_hnoc_centre_router;
    localparam int NP = 4;
    localparam int DW = 36;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hnoc_centre_router_if #(.NumPorts(NP), .DataWidth(DW)) bus ();

    hnoc_centre_router dut (
        .i_sclk       (clk),
        .i_reset      (rst_n),
        .i_data       (bus.in_data),
        .i_data_valid (bus.in_valid),
        .o_data_ready (bus.in_ready),
        .o_data       (bus.out_data),
        .o_data_valid (bus.out_valid),
        .i_data_ready (bus.out_ready)
    );

    typedef struct packed {
        logic [1:0]  port;
        logic [35:0] data;
        logic [31:0] cyc;
    } ev_t;

    ev_t         evq[$];
    int unsigned nvec = 0;
    int unsigned nmis = 0;
    logic [31:0] cyc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Egress transfers complete on the next rising edge; inputs only move just after an edge.
    always @(negedge clk) begin
        if (rst_n)
            for (int p = 0; p < NP; p++)
                if (bus.out_valid[p] && bus.out_ready[p])
                    evq.push_back(ev_t'{port: 2'(p), data: bus.out_data[p*DW +: DW], cyc: cyc});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] flit(input logic [3:0] d, input logic [31:0] pl);
        return {d, pl};
    endfunction

    task automatic drive(input int p, input logic v, input logic [35:0] d);
        bus.in_data[p*DW +: DW] = d;
        bus.in_valid[p]         = v;
    endtask

    function automatic int cnt_port(input int p);
        int n = 0;
        foreach (evq[k]) if (int'(evq[k].port) == p) n++;
        return n;
    endfunction

    function automatic ev_t nth(input int p, input int idx);
        int   n = 0;
        ev_t  e = '{port: 2'b11, data: 36'hF_FFFF_FFFF, cyc: 32'hFFFF_FFFF};
        foreach (evq[k])
            if (int'(evq[k].port) == p) begin
                if (n == idx) e = evq[k];
                n++;
            end
        return e;
    endfunction

    // Stream flits on port0 toward port1, counting how many the router accepts.
    task automatic fill0(input logic [31:0] base, output int acc);
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.in_ready[0]) begin
                drive(0, 1'b1, flit(4'h4, base + 32'(acc)));
                acc++;
            end
            tick();
        end
        drive(0, 1'b0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.out_ready = '1;

        tick(3);
        chk("rst_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_ready", 64'(bus.in_ready), 64'h0);
        chk("rst_data",  64'(bus.out_data[DW-1:0]), 64'h0);
        rst_n = 1'b1;
        chk("rel_ready_pre", 64'(bus.in_ready), 64'h0);
        tick();
        chk("rel_ready_post", 64'(bus.in_ready), 64'hF);

        // dest 3 is owned by port0; 2-edge latency
        drive(0, 1'b1, 36'h3_0000_0001);
        tick();
        drive(0, 1'b0, '0);
        tick();
        chk("lat_n1_valid", 64'(bus.out_valid), 64'h0);
        tick();
        chk("lat_n2_valid", 64'(bus.out_valid), 64'h1);
        chk("lat_n2_data", 64'(bus.out_data[0 +: DW]), 64'h3_0000_0001);
        tick();
        chk("lat_drained", 64'(bus.out_valid), 64'h0);

        // unmatched dest goes to the uplink
        evq.delete();
        drive(1, 1'b1, flit(4'hE, 32'h1234_5678));
        tick();
        drive(1, 1'b0, '0);
        tick(4);
        chk("dflt_count", 64'(cnt_port(3)), 64'd1);
        chk("dflt_data", 64'(nth(3, 0).data), 64'hE_1234_5678);
        chk("dflt_total", 64'(evq.size()), 64'd1);

        // three inputs contend for port1
        evq.delete();
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 3; p++) drive(p, 1'b1, flit(4'h5, 32'(p*256 + k)));
            tick();
        end
        for (int p = 0; p < 3; p++) drive(p, 1'b0, '0);
        tick(16);
        chk("rr_count", 64'(cnt_port(1)), 64'd12);
        for (int n = 0; n < 12; n++)
            chk($sformatf("rr_order%0d", n), 64'(nth(1, n).data), 64'(flit(4'h5, 32'((n % 3)*256 + n/3))));
        chk("rr_rate", 64'(nth(1, 11).cyc - nth(1, 0).cyc), 64'd11);

        // backpressure: 4 FIFO + 1 output register
        evq.delete();
        bus.out_ready[1] = 1'b0;
        fill0(32'h100, acc);
        chk("bp_accepted", 64'(acc), 64'd5);
        chk("bp_ready0", 64'(bus.in_ready[0]), 64'h0);
        chk("bp_hold_vld", 64'(bus.out_valid[1]), 64'h1);
        chk("bp_hold_data", 64'(bus.out_data[DW +: DW]), 64'(flit(4'h4, 32'h100)));
        tick(3);
        chk("bp_hold_data2", 64'(bus.out_data[DW +: DW]), 64'(flit(4'h4, 32'h100)));
        bus.out_ready[1] = 1'b1;
        tick(10);
        chk("bp_drain_cnt", 64'(cnt_port(1)), 64'd5);
        for (int n = 0; n < 5; n++)
            chk($sformatf("bp_drain%0d", n), 64'(nth(1, n).data), 64'(flit(4'h4, 32'h100 + 32'(n))));

        // full FIFO: pop frees exactly one slot, refill keeps order
        evq.delete();
        bus.out_ready[1] = 1'b0;
        fill0(32'h200, acc);
        chk("full_accepted", 64'(acc), 64'd5);
        drive(0, 1'b1, flit(4'h4, 32'h205));
        bus.out_ready[1] = 1'b1;
        chk("full_ready_lo", 64'(bus.in_ready[0]), 64'h0);
        tick();
        bus.out_ready[1] = 1'b0;
        chk("full_slot_free", 64'(bus.in_ready[0]), 64'h1);
        tick();
        drive(0, 1'b0, '0);
        chk("full_again", 64'(bus.in_ready[0]), 64'h0);
        bus.out_ready[1] = 1'b1;
        tick(10);
        chk("full_cnt", 64'(cnt_port(1)), 64'd6);
        for (int n = 0; n < 6; n++)
            chk($sformatf("full_ord%0d", n), 64'(nth(1, n).data), 64'(flit(4'h4, 32'h200 + 32'(n))));

        // mid-stream reset discards in-flight flits
        evq.delete();
        for (int c = 0; c < 3; c++) begin
            drive(0, 1'b1, flit(4'h8, 32'h300 + 32'(c)));
            tick();
        end
        rst_n = 1'b0;
        drive(0, 1'b0, '0);
        #1;
        chk("mrst_valid", 64'(bus.out_valid), 64'h0);
        chk("mrst_ready", 64'(bus.in_ready), 64'h0);
        tick();
        rst_n = 1'b1;
        chk("mrst_ready_pre", 64'(bus.in_ready), 64'h0);
        tick();
        chk("mrst_ready_post", 64'(bus.in_ready), 64'hF);
        tick(6);
        chk("mrst_discard", 64'(evq.size()), 64'd0);

        // U-turn: port2 to its own range
        drive(2, 1'b1, flit(4'h9, 32'hCAFE));
        tick();
        drive(2, 1'b0, '0);
        tick(4);
        chk("uturn_cnt", 64'(cnt_port(2)), 64'd1);
        chk("uturn_data", 64'(nth(2, 0).data), 64'(flit(4'h9, 32'hCAFE)));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
